cube_frame_buffer: RTL and testbench
====================================

Name: cube_frame_buffer

Overview:
Double-buffered 64-byte frame store directly upstream of the single-frame scan stage. The host writes a complete 8x8x8 frame into the back bank through a valid/ready port. The scan stage reads bytes from the front bank using its 6-bit {layer, latch} address. Banks swap only on a frame boundary, after the front frame has been scanned a minimum number of times, so no frame is ever displayed partially updated.

Parameters:
MIN_REPEATS, 4, minimum completed scans of the front frame before a swap is allowed (range 1..255)
CNT_W, 8, width of the scan repeat counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  host write request
wr_ready  out  1  back bank can accept a write
wr_addr  in  6  byte address {layer[2:0], latch[2:0]}
wr_data  in  8  byte value
wr_last  in  1  qualifies the final write of a frame; commits the back bank
rd_addr  in  6  scan-stage byte address
rd_data  out  8  front-bank byte at rd_addr
frame_done  in  1  frame-complete level from the scan stage
scan_start  out  1  one-cycle pulse that starts the scan stage
frame_swapped  out  1  one-cycle pulse when the banks swap
front_bank  out  1  index of the bank being displayed

Behaviour:
- Reset (async, active-high) sets: state=IDLE, wr_ready=1, pending=0, front_bank=0, scan_cnt=0, scan_start=0, frame_swapped=0, frame_done edge register=0. Bank contents are not reset.
- rd_data: combinational read from the front bank, zero latency. Forced to 8'h00 while state=IDLE.
- Write acceptance: a write is accepted when wr_valid && wr_ready. It writes the back bank (~front_bank) at wr_addr on that edge. Unwritten bytes keep their old values.
- Commit: an accepted write with wr_last=1 sets pending=1 and wr_ready=0 on the same edge. wr_valid is ignored while wr_ready=0.
- frame_done is a level. Only its rising edge (registered previous value) counts as one completed scan.
- FSM states:
  - IDLE: on commit, next edge goes to START and flips front_bank. frame_swapped pulses in the START cycle.
  - START: scan_start=1 for exactly one cycle, pending cleared, wr_ready=1. Next state is RUN.
  - RUN: on each frame_done rise, scan_cnt increments, saturating at 2^CNT_W-1.
- Swap in RUN: occurs on a frame_done rise when pending=1 and scan_cnt+1 >= MIN_REPEATS. On that edge: front_bank flips, scan_cnt=0, pending=0, frame_swapped=1 for one cycle, wr_ready=1 from the next cycle.
- Commit on the same edge as a frame_done rise: the swap decision uses the pre-edge pending value. No swap on that edge; the swap happens at the next eligible rise.
- No pending frame: the front frame repeats indefinitely; scan_cnt saturates.
- MIN_REPEATS=1: swap at the first frame_done rise after commit.
- Reset mid-write or mid-scan: all state returns to reset values immediately. The partial back-bank contents are discarded by protocol, since front_bank=0 and pending=0.
- The scan stage's stop input is tied low at top level; this block never stops scanning once in RUN.

Optional Feature:
- Macro CUBE_FB_HOLD_EN.
- When defined, adds input hold (1 bit). While hold=1 in RUN:
  - swaps are suppressed; pending stays set and wr_ready stays 0;
  - scan_cnt keeps counting.
- When hold drops, the swap occurs at the next eligible frame_done rise.
- When not defined: no hold port, and behaviour is as above.

Decomposition:
- Package cube_pkg:
  - CUBE_DIM=8, ADDR_W=6, FRAME_BYTES=64, DATA_W=8;
  - typedef cube_addr_t (logic [5:0]);
  - typedef cube_byte_t (logic [7:0]);
  - enum fb_state_t {IDLE, START, RUN}.
- Sub-module cube_fb_bank: 64x8 register file with one synchronous write port and one combinational read port, instantiated twice. Write enable is steered by front_bank; the read mux selects the front bank.

Test Plan:
1. Reset, then write 64 bytes with byte = address and wr_last on address 63 -> frame_swapped and IDLE->START in the cycle after commit, scan_start high exactly 1 cycle, front_bank=1, rd_addr=6'd37 gives rd_data=8'h25.
2. In RUN with MIN_REPEATS=4, commit frame B (all 8'hFF) after 1 frame_done rise -> wr_ready=0; swap on the 4th rise, not the 3rd; rd_data=8'hFF afterwards; wr_ready=1 one cycle after the swap.
3. frame_done held high 10 cycles -> scan_cnt increments by exactly 1.
4. Commit on the same edge as a frame_done rise with scan_cnt=3 -> no swap that edge; swap at the next rise.
5. wr_valid held with wr_ready=0 and data 8'h00 -> back bank unchanged; the later-displayed frame is uncorrupted.
6. Assert rst mid-write after 20 bytes -> wr_ready=1, state=IDLE, rd_data=8'h00, no scan_start; a full rewrite then restarts normally. With CUBE_FB_HOLD_EN defined: hold=1 over 10 rises -> no swap; release -> swap at the next rise.

Source files
------------

// File: rtl/cube_pkg.sv
// -----------------------------------------------------------------------------
// cube_pkg
// Shared constants and types for the 8x8x8 cube frame buffer.
//   CUBE_DIM    : cube edge length (layers, latches, bits per latch byte)
//   ADDR_W      : byte address width, {layer[2:0], latch[2:0]}
//   FRAME_BYTES : bytes per frame
//   DATA_W      : byte width
//   fb_state_t  : frame buffer sequencing states
// -----------------------------------------------------------------------------
package cube_pkg;

  localparam int unsigned CUBE_DIM    = 8;
  localparam int unsigned ADDR_W      = 6;
  localparam int unsigned FRAME_BYTES = 64;
  localparam int unsigned DATA_W      = 8;

  typedef logic [5:0] cube_addr_t;
  typedef logic [7:0] cube_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } fb_state_t;

endpackage

// File: rtl/cube_fb_bank.sv
// -----------------------------------------------------------------------------
// cube_fb_bank
// One 64x8 frame bank: synchronous write port, combinational read port.
// Contents are deliberately not reset.
// Ports:
//   clk      : system clock
//   we_i     : write enable
//   waddr_i  : write byte address
//   wdata_i  : write byte value
//   raddr_i  : read byte address
//   rdata_o  : byte at raddr_i (zero latency)
// -----------------------------------------------------------------------------
module cube_fb_bank
  import cube_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [FRAME_BYTES];

  // Byte write into the register file.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cube_frame_buffer.sv
// -----------------------------------------------------------------------------
// cube_frame_buffer
// Double-buffered 64-byte frame store feeding the single-frame scan stage.
// The host fills the back bank; banks swap only on a scan boundary once the
// front frame has been scanned at least MIN_REPEATS times. The scan stage's
// stop input is tied low at the top level, so scanning never stops in RUN.
// Optional build macro: CUBE_FB_HOLD_EN adds the 'hold' input, which
// suppresses swaps while high (scan counting continues).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   hold            : (CUBE_FB_HOLD_EN only) suppress swaps while high
//   wr_valid/ready  : host write handshake into the back bank
//   wr_addr/data    : byte address {layer, latch} and value
//   wr_last         : final write of a frame, commits the back bank
//   rd_addr/rd_data : scan-stage read of the front bank (00 while IDLE)
//   frame_done      : scan-complete level; each rising edge is one scan
//   scan_start      : one-cycle pulse that starts the scan stage
//   frame_swapped   : one-cycle pulse when the banks swap
//   front_bank      : index of the bank being displayed
// -----------------------------------------------------------------------------
module cube_frame_buffer
  import cube_pkg::*;
#(
  parameter int unsigned MIN_REPEATS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CUBE_FB_HOLD_EN
  input  logic              hold,
`endif
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_done,
  output logic              scan_start,
  output logic              frame_swapped,
  output logic              front_bank
);

  // Compared one bit wider so scan_cnt+1 cannot wrap at saturation.
  localparam logic [CNT_W:0]   MIN_REP_C = (CNT_W + 1)'(MIN_REPEATS);
  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};

  fb_state_t        state_q, state_d;
  logic             front_q, front_d;
  logic             pending_q, pending_d;
  logic             wr_ready_q, wr_ready_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             scan_start_q, scan_start_d;
  logic             swapped_q, swapped_d;
  logic             fd_prev_q;

  logic             hold_s;
  logic             fd_rise_s;
  logic             wr_acc_s;
  logic             commit_s;
  logic [CNT_W:0]   cnt_inc_s;
  logic             swap_ok_s;
  logic [DATA_W-1:0] rdata0_s, rdata1_s;

`ifdef CUBE_FB_HOLD_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  assign fd_rise_s = frame_done & ~fd_prev_q;
  assign wr_acc_s  = wr_valid & wr_ready_q;
  assign commit_s  = wr_acc_s & wr_last;
  assign cnt_inc_s = {1'b0, scan_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  // pending_q is the pre-edge value, so a commit landing on the same rise
  // cannot swap on that rise.
  assign swap_ok_s = fd_rise_s & pending_q & (cnt_inc_s >= MIN_REP_C) & ~hold_s;

  // Bank 0 is written while bank 1 is displayed and vice versa.
  cube_fb_bank u_bank0 (
    .clk     (clk),
    .we_i    (wr_acc_s & front_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata0_s)
  );

  cube_fb_bank u_bank1 (
    .clk     (clk),
    .we_i    (wr_acc_s & ~front_q),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rdata1_s)
  );

  // Next-state logic: commit tracking, sequencing, scan counting and swap.
  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    pending_d    = pending_q;
    wr_ready_d   = wr_ready_q;
    scan_cnt_d   = scan_cnt_q;
    scan_start_d = 1'b0;
    swapped_d    = 1'b0;

    if (commit_s) begin
      pending_d  = 1'b1;
      wr_ready_d = 1'b0;
    end else begin
      pending_d  = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (commit_s) begin
          state_d      = START;
          front_d      = ~front_q;
          swapped_d    = 1'b1;
          scan_start_d = 1'b1;
        end else begin
          state_d      = IDLE;
        end
      end
      START: begin
        state_d    = RUN;
        pending_d  = 1'b0;
        wr_ready_d = 1'b1;
      end
      RUN: begin
        if (swap_ok_s) begin
          front_d    = ~front_q;
          scan_cnt_d = {CNT_W{1'b0}};
          pending_d  = 1'b0;
          swapped_d  = 1'b1;
          wr_ready_d = 1'b1;
        end else if (fd_rise_s && (scan_cnt_q != CNT_MAX_C)) begin
          scan_cnt_d = cnt_inc_s[CNT_W-1:0];
        end else begin
          scan_cnt_d = scan_cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      front_q      <= 1'b0;
      pending_q    <= 1'b0;
      wr_ready_q   <= 1'b1;
      scan_cnt_q   <= {CNT_W{1'b0}};
      scan_start_q <= 1'b0;
      swapped_q    <= 1'b0;
      fd_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      pending_q    <= pending_d;
      wr_ready_q   <= wr_ready_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_start_q <= scan_start_d;
      swapped_q    <= swapped_d;
      fd_prev_q    <= frame_done;
    end
  end

  assign wr_ready      = wr_ready_q;
  assign front_bank    = front_q;
  assign scan_start    = scan_start_q;
  assign frame_swapped = swapped_q;
  assign rd_data       = (state_q == IDLE) ? {DATA_W{1'b0}}
                       : (front_q ? rdata1_s : rdata0_s);

endmodule

// File: tb/tb_cube_frame_buffer.sv
// -----------------------------------------------------------------------------
// tb_cube_frame_buffer
// Directed self-checking bench for cube_frame_buffer (MIN_REPEATS=4, CNT_W=8).
// Inputs are driven and outputs sampled 1 ns after the rising clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cube_frame_buffer;
  import cube_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       hold = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [5:0] wr_addr = 6'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;
  logic       frame_done = 1'b0;
  logic       scan_start;
  logic       frame_swapped;
  logic       front_bank;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cube_frame_buffer #(.MIN_REPEATS(4), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef CUBE_FB_HOLD_EN
    .hold          (hold),
`endif
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_done    (frame_done),
    .scan_start    (scan_start),
    .frame_swapped (frame_swapped),
    .front_bank    (front_bank)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [5:0] a, input logic [7:0] d, input logic l);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_last  = l;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic rise();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_wr_ready got=%0b exp=1", wr_ready); end
    checks++; if (front_bank !== 1'b0) begin failures++; $display("FAIL rst_front got=%0b exp=0", front_bank); end
    checks++; if (scan_start !== 1'b0) begin failures++; $display("FAIL rst_scan_start got=%0b exp=0", scan_start); end
    checks++; if (frame_swapped !== 1'b0) begin failures++; $display("FAIL rst_swapped got=%0b exp=0", frame_swapped); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd_data got=%0h exp=00", rd_data); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.state_q); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_first_frame();
    for (int i = 0; i < 64; i++) wr_byte(6'(i), 8'(i), (i == 63));
    rd_addr = 6'd37;
    #1;
    checks++; if (dut.state_q !== START) begin failures++; $display("FAIL t1_state got=%0d exp=1", dut.state_q); end
    checks++; if (frame_swapped !== 1'b1) begin failures++; $display("FAIL t1_swapped got=%0b exp=1", frame_swapped); end
    checks++; if (scan_start !== 1'b1) begin failures++; $display("FAIL t1_scan_start got=%0b exp=1", scan_start); end
    checks++; if (front_bank !== 1'b1) begin failures++; $display("FAIL t1_front got=%0b exp=1", front_bank); end
    checks++; if (rd_data !== 8'h25) begin failures++; $display("FAIL t1_rd37 got=%0h exp=25", rd_data); end
    step();
    checks++; if (scan_start !== 1'b0) begin failures++; $display("FAIL t1_scan_start_1cyc got=%0b exp=0", scan_start); end
    checks++; if (frame_swapped !== 1'b0) begin failures++; $display("FAIL t1_swapped_1cyc got=%0b exp=0", frame_swapped); end
    checks++; if (dut.state_q !== RUN) begin failures++; $display("FAIL t1_run got=%0d exp=2", dut.state_q); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL t1_ready_run got=%0b exp=1", wr_ready); end
  endtask

  task automatic test_min_repeats();
    rise();  // rise 1
    for (int i = 0; i < 64; i++) wr_byte(6'(i), 8'hFF, (i == 63));
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL t2_ready_commit got=%0b exp=0", wr_ready); end
    rise();  // rise 2
    rise();  // rise 3
    checks++; if (front_bank !== 1'b1) begin failures++; $display("FAIL t2_no_swap_3rd got=%0b exp=1", front_bank); end
    checks++; if (rd_data !== 8'h25) begin failures++; $display("FAIL t2_rd_before got=%0h exp=25", rd_data); end
    frame_done = 1'b1;  // rise 4
    step();
    checks++; if (frame_swapped !== 1'b1) begin failures++; $display("FAIL t2_swap_4th got=%0b exp=1", frame_swapped); end
    checks++; if (front_bank !== 1'b0) begin failures++; $display("FAIL t2_front got=%0b exp=0", front_bank); end
    checks++; if (rd_data !== 8'hFF) begin failures++; $display("FAIL t2_rd_after got=%0h exp=ff", rd_data); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL t2_ready_after got=%0b exp=1", wr_ready); end
    frame_done = 1'b0;
    step();
    checks++; if (frame_swapped !== 1'b0) begin failures++; $display("FAIL t2_swapped_1cyc got=%0b exp=0", frame_swapped); end
  endtask

  task automatic test_level_done();
    frame_done = 1'b1;
    for (int i = 0; i < 10; i++) step();
    frame_done = 1'b0;
    step();
    checks++; if (dut.scan_cnt_q !== 8'd1) begin failures++; $display("FAIL t3_scan_cnt got=%0d exp=1", dut.scan_cnt_q); end
  endtask

  task automatic test_commit_on_rise();
    rise();
    rise();  // scan_cnt now 3
    checks++; if (dut.scan_cnt_q !== 8'd3) begin failures++; $display("FAIL t4_cnt_pre got=%0d exp=3", dut.scan_cnt_q); end
    for (int i = 0; i < 63; i++) wr_byte(6'(i), {2'b10, 6'(i)}, 1'b0);
    frame_done = 1'b1;
    wr_byte(6'd63, 8'hBF, 1'b1);
    checks++; if (frame_swapped !== 1'b0) begin failures++; $display("FAIL t4_no_swap got=%0b exp=0", frame_swapped); end
    checks++; if (front_bank !== 1'b0) begin failures++; $display("FAIL t4_front_hold got=%0b exp=0", front_bank); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL t4_ready got=%0b exp=0", wr_ready); end
    frame_done = 1'b0;
    step();
    frame_done = 1'b1;
    step();
    checks++; if (frame_swapped !== 1'b1) begin failures++; $display("FAIL t4_swap_next got=%0b exp=1", frame_swapped); end
    checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL t4_rd37 got=%0h exp=a5", rd_data); end
    frame_done = 1'b0;
    step();
  endtask

  task automatic test_blocked_writes();
    for (int i = 0; i < 64; i++) wr_byte(6'(i), {2'b01, 6'(i)}, (i == 63));
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    for (int i = 0; i < 64; i++) begin
      wr_addr = 6'(i);
      wr_last = (i == 10);
      step();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL t5_ready got=%0b exp=0", wr_ready); end
    rise();
    rise();
    rise();
    checks++; if (front_bank !== 1'b1) begin failures++; $display("FAIL t5_front_pre got=%0b exp=1", front_bank); end
    rise();
    checks++; if (front_bank !== 1'b0) begin failures++; $display("FAIL t5_front_post got=%0b exp=0", front_bank); end
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      #1;
      checks++; if (rd_data !== {2'b01, 6'(i)}) begin failures++; $display("FAIL t5_frame addr=%0d got=%0h exp=%0h", i, rd_data, {2'b01, 6'(i)}); end
    end
    rd_addr = 6'd37;
  endtask

  task automatic test_reset_mid_write();
    for (int i = 0; i < 20; i++) wr_byte(6'(i), 8'h11, 1'b0);
    rst = 1'b1;
    #2;
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL t6_ready got=%0b exp=1", wr_ready); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL t6_state got=%0d exp=0", dut.state_q); end
    checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL t6_rd got=%0h exp=00", rd_data); end
    checks++; if (front_bank !== 1'b0) begin failures++; $display("FAIL t6_front got=%0b exp=0", front_bank); end
    step();
    step();
    checks++; if (scan_start !== 1'b0) begin failures++; $display("FAIL t6_scan_start got=%0b exp=0", scan_start); end
    rst = 1'b0;
    step();
    for (int i = 0; i < 64; i++) wr_byte(6'(i), {2'b11, 6'(i)}, (i == 63));
    checks++; if (scan_start !== 1'b1) begin failures++; $display("FAIL t6_restart got=%0b exp=1", scan_start); end
    checks++; if (front_bank !== 1'b1) begin failures++; $display("FAIL t6_front_new got=%0b exp=1", front_bank); end
    checks++; if (rd_data !== 8'hE5) begin failures++; $display("FAIL t6_rd37 got=%0h exp=e5", rd_data); end
    rd_addr = 6'd5;
    #1;
    checks++; if (rd_data !== 8'hC5) begin failures++; $display("FAIL t6_rd5 got=%0h exp=c5", rd_data); end
    rd_addr = 6'd37;
    step();
  endtask

`ifdef CUBE_FB_HOLD_EN
  task automatic test_hold();
    for (int i = 0; i < 64; i++) wr_byte(6'(i), 8'h33, (i == 63));
    hold = 1'b1;
    for (int i = 0; i < 10; i++) rise();
    checks++; if (front_bank !== 1'b1) begin failures++; $display("FAIL th_no_swap got=%0b exp=1", front_bank); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL th_ready got=%0b exp=0", wr_ready); end
    checks++; if (dut.scan_cnt_q !== 8'd10) begin failures++; $display("FAIL th_cnt got=%0d exp=10", dut.scan_cnt_q); end
    hold = 1'b0;
    step();
    frame_done = 1'b1;
    step();
    checks++; if (frame_swapped !== 1'b1) begin failures++; $display("FAIL th_swap got=%0b exp=1", frame_swapped); end
    checks++; if (rd_data !== 8'h33) begin failures++; $display("FAIL th_rd got=%0h exp=33", rd_data); end
    frame_done = 1'b0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_min_repeats();
    test_level_done();
    test_commit_on_rise();
    test_blocked_writes();
    test_reset_mid_write();
`ifdef CUBE_FB_HOLD_EN
    test_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
